// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the shared word-wide
// backing memory. The arbiter takes the slave view; the cache/memory
// environment takes the master view.
interface mem_arbiter_if;
  // icache side
  logic         IC_READ;
  logic [5:0]   IC_ADDRESS;
  logic [127:0] IC_READDATA;
  logic         IC_BUSYWAIT;
  // dcache side
  logic         DC_READ;
  logic         DC_WRITE;
  logic [5:0]   DC_ADDRESS;
  logic [31:0]  DC_WRITEDATA;
  logic [31:0]  DC_READDATA;
  logic         DC_BUSYWAIT;
  // backing memory side
  logic         M_READ;
  logic         M_WRITE;
  logic [8:0]   M_ADDRESS;
  logic [31:0]  M_WRITEDATA;
  logic [31:0]  M_READDATA;
  logic         M_BUSYWAIT;

  modport slave (
    input  IC_READ, IC_ADDRESS, DC_READ, DC_WRITE, DC_ADDRESS, DC_WRITEDATA,
           M_READDATA, M_BUSYWAIT,
    output IC_READDATA, IC_BUSYWAIT, DC_READDATA, DC_BUSYWAIT,
           M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
  );

  modport master (
    output IC_READ, IC_ADDRESS, DC_READ, DC_WRITE, DC_ADDRESS, DC_WRITEDATA,
           M_READDATA, M_BUSYWAIT,
    input  IC_READDATA, IC_BUSYWAIT, DC_READDATA, DC_BUSYWAIT,
           M_READ, M_WRITE, M_ADDRESS, M_WRITEDATA
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one word-wide backing memory between a
// dcache (single-word blocks) and an icache (four-word blocks fetched as a
// burst with a one-cycle gap between beats). A burst is never preempted.
module mem_arbiter #(
  parameter logic [8:0] DATA_BASE = 9'h100,
  parameter logic [8:0] IMEM_BASE = 9'h000
) (
  input logic          CLK,
  input logic          RESET,
  mem_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_ACC  = 3'd1,
    D_DONE = 3'd2,
    I_ACC  = 3'd3,
    I_GAP  = 3'd4,
    I_DONE = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  // Set once an ACC state has been held for a full cycle; a word may only
  // complete after that, so a stale low M_BUSYWAIT on entry is ignored.
  logic         held_q, held_d;
  logic [31:0]  dc_rdata_q, dc_rdata_d;
  logic [127:0] ic_rdata_q, ic_rdata_d;

  logic         dc_req;
  logic         word_done;
  logic         m_read;
  logic         m_write;
  logic [8:0]   m_address;
  logic [31:0]  m_writedata;

  assign dc_req    = bus.DC_READ | bus.DC_WRITE;
  assign word_done = held_q & ~bus.M_BUSYWAIT;

  // State, beat counter, hold flag and captured block data
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      held_q     <= 1'b0;
      dc_rdata_q <= '0;
      ic_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      held_q     <= held_d;
      dc_rdata_q <= dc_rdata_d;
      ic_rdata_q <= ic_rdata_d;
    end
  end

  // Next-state selection, word capture and memory request decode
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    held_d      = 1'b0;
    dc_rdata_d  = dc_rdata_q;
    ic_rdata_d  = ic_rdata_q;
    m_read      = 1'b0;
    m_write     = 1'b0;
    m_address   = '0;
    m_writedata = '0;
    case (state_q)
      IDLE: begin
        beat_d = 2'd0;
        if (dc_req) begin
          state_d = D_ACC;
        end else if (bus.IC_READ) begin
          state_d = I_ACC;
        end
      end
      D_ACC: begin
        // Both strobes at once is illegal; the write wins.
        m_write     = bus.DC_WRITE;
        m_read      = bus.DC_READ & ~bus.DC_WRITE;
        m_address   = DATA_BASE + {3'b000, bus.DC_ADDRESS};
        m_writedata = bus.DC_WRITEDATA;
        if (word_done) begin
          state_d = D_DONE;
          if (m_read) begin
            dc_rdata_d = bus.M_READDATA;
          end
        end else begin
          held_d = 1'b1;
        end
      end
      I_ACC: begin
        m_read    = 1'b1;
        m_address = IMEM_BASE + {1'b0, bus.IC_ADDRESS, beat_q};
        if (word_done) begin
          ic_rdata_d[{beat_q, 5'b00000} +: 32] = bus.M_READDATA;
          state_d = (beat_q == 2'd3) ? I_DONE : I_GAP;
        end else begin
          held_d = 1'b1;
        end
      end
      I_GAP: begin
        beat_d  = beat_q + 2'd1;
        state_d = I_ACC;
      end
      D_DONE, I_DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.M_READ      = m_read;
  assign bus.M_WRITE     = m_write;
  assign bus.M_ADDRESS   = m_address;
  assign bus.M_WRITEDATA = m_writedata;
  assign bus.DC_READDATA = dc_rdata_q;
  assign bus.IC_READDATA = ic_rdata_q;
  // Stalls release only during the DONE cycle of the matching cache.
  assign bus.DC_BUSYWAIT = dc_req & (state_q != D_DONE);
  assign bus.IC_BUSYWAIT = bus.IC_READ & (state_q != I_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-programmable backing memory, a
// schedule-based reference model of the expected bus timeline, a per-cycle
// compare process, directed scenarios and a randomized request mix.
module tb_mem_arbiter;
  localparam logic [8:0] DATA_BASE = 9'h100;
  localparam logic [8:0] IMEM_BASE = 9'h000;

  localparam int S_DACC  = 0;
  localparam int S_DDONE = 1;
  localparam int S_IACC  = 2;
  localparam int S_IGAP  = 3;
  localparam int S_IDONE = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.DATA_BASE(DATA_BASE), .IMEM_BASE(IMEM_BASE)) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int lm = 4;

  logic [31:0] mem     [512];
  logic [31:0] ref_mem [512];

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] data;
  } op_t;
  op_t oplog[$];

  typedef struct {
    int         kind;
    logic [8:0] addr;
    bit         fin;
    int         beat;
  } slot_t;
  slot_t sched[$];

  logic [127:0] exp_ic;
  logic [31:0]  exp_dc;

  bit  m_active;
  int  m_cnt;
  time t_rst;
  time t_mread_fall;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Backing memory: Lm cycles per word counting the arbiter's hold cycle.
  assign bus.M_READDATA = mem[bus.M_ADDRESS];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_cnt = 0;
      bus.M_BUSYWAIT <= 1'b0;
    end else if (!m_active) begin
      if (bus.M_READ || bus.M_WRITE) begin
        m_active = 1'b1;
        m_cnt = 1;
        bus.M_BUSYWAIT <= (lm > 2);
      end
    end else if (bus.M_BUSYWAIT) begin
      m_cnt++;
      if (m_cnt == lm - 1) bus.M_BUSYWAIT <= 1'b0;
    end else begin
      m_active = 1'b0;
      if (bus.M_WRITE) begin
        mem[bus.M_ADDRESS] = bus.M_WRITEDATA;
        oplog.push_back('{1'b1, bus.M_ADDRESS, bus.M_WRITEDATA});
      end else begin
        oplog.push_back('{1'b0, bus.M_ADDRESS, bus.M_READDATA});
      end
    end
  end

  always @(negedge bus.M_READ) t_mread_fall = $time;

  // Reference model: a job becomes a timeline of slots when the arbiter is
  // idle; one slot is consumed per clock edge.
  always @(posedge clk or posedge rst) begin : model
    slot_t s;
    int    a;
    if (rst) begin
      sched.delete();
      exp_ic = '0;
      exp_dc = '0;
    end else if (sched.size() != 0) begin
      s = sched.pop_front();
      if (s.fin) begin
        if (s.kind == S_IACC) exp_ic[s.beat*32 +: 32] = ref_mem[s.addr];
        else if (bus.DC_WRITE) ref_mem[s.addr] = bus.DC_WRITEDATA;
        else exp_dc = ref_mem[s.addr];
      end
    end else if (bus.DC_READ || bus.DC_WRITE) begin
      a = (int'(DATA_BASE) + int'(bus.DC_ADDRESS)) % 512;
      for (int i = 0; i < lm; i++) sched.push_back('{S_DACC, 9'(a), i == lm - 1, 0});
      sched.push_back('{S_DDONE, 9'd0, 1'b0, 0});
    end else if (bus.IC_READ) begin
      for (int k = 0; k < 4; k++) begin
        a = (int'(IMEM_BASE) + int'(bus.IC_ADDRESS) * 4 + k) % 512;
        for (int i = 0; i < lm; i++) sched.push_back('{S_IACC, 9'(a), i == lm - 1, k});
        if (k < 3) sched.push_back('{S_IGAP, 9'd0, 1'b0, k});
      end
      sched.push_back('{S_IDONE, 9'd0, 1'b0, 0});
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : compare
    logic       e_rd, e_wr, e_dcb, e_icb;
    logic [8:0] e_addr;
    logic [31:0] e_wd;
    int         k;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wd = '0;
    k = (sched.size() != 0) ? sched[0].kind : -1;
    if (k == S_DACC) begin
      e_wr   = bus.DC_WRITE;
      e_rd   = bus.DC_READ & ~bus.DC_WRITE;
      e_addr = sched[0].addr;
      e_wd   = bus.DC_WRITEDATA;
    end else if (k == S_IACC) begin
      e_rd   = 1'b1;
      e_addr = sched[0].addr;
    end
    e_dcb = (bus.DC_READ | bus.DC_WRITE) & (k != S_DDONE);
    e_icb = bus.IC_READ & (k != S_IDONE);
    chk("m_read", bus.M_READ, e_rd);
    chk("m_write", bus.M_WRITE, e_wr);
    chk("m_address", bus.M_ADDRESS, e_addr);
    chk("m_writedata", bus.M_WRITEDATA, e_wd);
    chk("dc_busywait", bus.DC_BUSYWAIT, e_dcb);
    chk("ic_busywait", bus.IC_BUSYWAIT, e_icb);
    chk("dc_readdata", bus.DC_READDATA, exp_dc);
    chk("ic_readdata", bus.IC_READDATA, exp_ic);
  end

  task automatic raise(input bit dr, input bit dw, input bit ir,
                       input logic [5:0] da, input logic [5:0] ia, input logic [31:0] wd);
    @(posedge clk); #1;
    bus.DC_READ = dr; bus.DC_WRITE = dw; bus.IC_READ = ir;
    bus.DC_ADDRESS = da; bus.IC_ADDRESS = ia; bus.DC_WRITEDATA = wd;
  endtask

  // Acts as both caches: each drops its request after the edge that ends
  // the cycle in which it saw its busywait low. Cycle 1 is the request cycle.
  task automatic run(input int inject_cyc, input logic [5:0] inj_addr,
                     output int dc_low, output int ic_low);
    int cyc;
    bit dd, id;
    cyc = 0; dc_low = -1; ic_low = -1;
    while ((bus.DC_READ || bus.DC_WRITE || bus.IC_READ || cyc < inject_cyc) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      dd = (bus.DC_READ | bus.DC_WRITE) & ~bus.DC_BUSYWAIT;
      id = bus.IC_READ & ~bus.IC_BUSYWAIT;
      if (dd && dc_low < 0) dc_low = cyc;
      if (id && ic_low < 0) ic_low = cyc;
      @(posedge clk); #1;
      if (dd) begin bus.DC_READ = 1'b0; bus.DC_WRITE = 1'b0; end
      if (id) bus.IC_READ = 1'b0;
      if (cyc == inject_cyc) begin bus.DC_READ = 1'b1; bus.DC_ADDRESS = inj_addr; end
    end
    chk("served_within_budget", cyc < 400, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  dl, il, kind;
    bit  found;
    logic [31:0] v;
    rst = 1'b1;
    bus.IC_READ = 0; bus.IC_ADDRESS = 0; bus.DC_READ = 0; bus.DC_WRITE = 0;
    bus.DC_ADDRESS = 0; bus.DC_WRITEDATA = 0;
    for (int i = 0; i < 512; i++) begin
      v = $urandom; mem[i] = v; ref_mem[i] = v;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_read", bus.M_READ, 1'b0);
    chk("reset_m_address", bus.M_ADDRESS, 9'h000);
    chk("reset_ic_readdata", bus.IC_READDATA, 128'h0);
    bus.IC_READ = 1'b1;
    #1;
    chk("reset_ic_stall", bus.IC_BUSYWAIT, 1'b1);
    bus.IC_READ = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Data read, 4-cycle memory
    lm = 4; mem[9'h105] = 32'hDEADBEEF; ref_mem[9'h105] = 32'hDEADBEEF;
    oplog.delete();
    raise(1, 0, 0, 6'h05, 6'h00, 32'h0);
    run(-1, 6'h0, dl, il);
    chk("rd_busy_low_cycle", dl, 6);
    chk("rd_op_count", oplog.size(), 1);
    chk("rd_op_addr", oplog[0].addr, 9'h105);
    chk("rd_op_is_read", oplog[0].wr, 1'b0);
    chk("rd_dc_readdata", bus.DC_READDATA, 32'hDEADBEEF);

    // Data write at the top of the data region
    oplog.delete();
    raise(0, 1, 0, 6'h3F, 6'h00, 32'h12345678);
    run(-1, 6'h0, dl, il);
    chk("wr_op_count", oplog.size(), 1);
    chk("wr_op_addr", oplog[0].addr, 9'h13F);
    chk("wr_op_is_write", oplog[0].wr, 1'b1);
    chk("wr_op_data", oplog[0].data, 32'h12345678);
    chk("wr_mem_word", mem[9'h13F], 32'h12345678);

    // Instruction block fetch
    for (int i = 0; i < 4; i++) begin
      mem[8 + i] = 32'(i + 1); ref_mem[8 + i] = 32'(i + 1);
    end
    oplog.delete();
    raise(0, 0, 1, 6'h00, 6'h02, 32'h0);
    run(-1, 6'h0, dl, il);
    chk("if_op_count", oplog.size(), 4);
    for (int i = 0; i < 4 && i < oplog.size(); i++)
      chk("if_op_addr", oplog[i].addr, 9'(8 + i));
    chk("if_block", bus.IC_READDATA, 128'h00000004_00000003_00000002_00000001);

    // Simultaneous requests: data first
    oplog.delete();
    raise(1, 0, 1, 6'h05, 6'h02, 32'h0);
    run(-1, 6'h0, dl, il);
    chk("cont_dc_low_cycle", dl, 6);
    chk("cont_ic_after_dc", il > dl, 1'b1);
    chk("cont_op_count", oplog.size(), 5);
    chk("cont_first_is_data", oplog[0].addr, 9'h105);
    chk("cont_then_fetch", oplog[1].addr, 9'h008);

    // Data request during fetch beat 1 must wait for the whole burst
    lm = 3; oplog.delete();
    raise(0, 0, 1, 6'h00, 6'h02, 32'h0);
    run(6, 6'h07, dl, il);
    chk("pre_op_count", oplog.size(), 5);
    for (int i = 0; i < 4 && i < oplog.size(); i++)
      chk("pre_fetch_addr", oplog[i].addr, 9'(8 + i));
    chk("pre_data_last", oplog[4].addr, 9'h107);
    chk("pre_dc_after_ic", dl > il, 1'b1);

    // Reset during beat 2 abandons the burst
    oplog.delete();
    raise(0, 0, 1, 6'h00, 6'h10, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (oplog.size() == 2 && bus.M_READ) found = 1'b1;
    end
    chk("rst_reached_beat2", found, 1'b1);
    t_rst = $time;
    rst = 1'b1;
    #1;
    chk("rst_strobe_same_time", t_mread_fall, t_rst);
    chk("rst_m_read", bus.M_READ, 1'b0);
    chk("rst_m_write", bus.M_WRITE, 1'b0);
    chk("rst_m_address", bus.M_ADDRESS, 9'h000);
    chk("rst_m_writedata", bus.M_WRITEDATA, 32'h0);
    chk("rst_ic_readdata", bus.IC_READDATA, 128'h0);
    chk("rst_dc_readdata", bus.DC_READDATA, 32'h0);
    chk("rst_ic_stall", bus.IC_BUSYWAIT, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    oplog.delete();
    rst = 1'b0;
    run(-1, 6'h0, dl, il);
    chk("rst_restart_count", oplog.size(), 4);
    chk("rst_restart_beat0", oplog[0].addr, 9'h040);
    chk("rst_block", bus.IC_READDATA, {mem[9'h043], mem[9'h042], mem[9'h041], mem[9'h040]});

    // Randomized mix, including the illegal read+write combination
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      lm = $urandom_range(2, 5);
      raise(kind == 0 || kind == 3 || kind == 4, kind == 1 || kind == 4, kind == 2 || kind == 3,
            6'($urandom), 6'($urandom), $urandom);
      run(-1, 6'h0, dl, il);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
